// File: rtl/cache_arbiter_pkg.sv
// Shared types and constants for the two-requester cache port arbiter.
package cache_arbiter_pkg;

    localparam int NUM_REQ                = 2;
    localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        SETTLE = 3'd2,
        WAIT   = 3'd3,
        DONE   = 3'd4
    } arb_state_t;

    // One-hot grant vector for a requester index.
    function automatic logic [NUM_REQ-1:0] onehot_of(input logic sel);
        logic [NUM_REQ-1:0] vec;
        if (sel) begin
            vec = 2'b10;
        end else begin
            vec = 2'b01;
        end
        return vec;
    endfunction

endpackage

// File: rtl/cache_arbiter_rr_picker.sv
// Combinational two-way round-robin choice: a lone request wins, a tie goes
// to the requester that was not served last.
module rr_picker (
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    // Winner selection from the request vector and the last-served index.
    always_comb begin
        valid  = 1'b0;
        winner = 1'b0;
        case (req)
            2'b01: begin
                valid  = 1'b1;
                winner = 1'b0;
            end
            2'b10: begin
                valid  = 1'b1;
                winner = 1'b1;
            end
            2'b11: begin
                valid  = 1'b1;
                winner = ~last;
            end
            default: begin
                valid  = 1'b0;
                winner = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/cache_arbiter.sv
// Round-robin arbiter serialising two requesters onto the single cache port;
// every output comes straight from a register.
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic [3:0]  wstrb0,
    input  logic [3:0]  wstrb1,
    output logic [1:0]  done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [1:0]  grant,
    output logic [31:0] cache_address,
    output logic [31:0] cache_data_in,
    output logic [3:0]  cache_write_enable,
    input  logic [31:0] cache_data_out,
    input  logic        cache_data_out_ready,
    input  logic        cache_busy
);

    localparam int             CNT_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t         state_q, state_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         grant_q, grant_d;
    logic [1:0]         done_q, done_d;
    logic               err_q, err_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         wen_q, wen_d;

    logic               pick_valid;
    logic               pick_winner;
    logic               is_write;
    logic               complete;

    rr_picker u_picker (
        .req    (req),
        .last   (last_q),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    // The write-enable register still holds the strobe of the active command
    // until DONE, so it doubles as the read/write flag during WAIT.
    assign is_write = (wen_q != 4'b0000);
    assign complete = ~cache_busy & (is_write | cache_data_out_ready);

    // Next-state and next-output computation for the arbitration FSM.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        done_d  = 2'b00;
        err_d   = err_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wen_d   = wen_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = onehot_of(pick_winner);
                    last_d  = pick_winner;
                    cnt_d   = '0;
                    if (pick_winner) begin
                        addr_d  = addr1;
                        wdata_d = wdata1;
                        wen_d   = wstrb1;
                    end else begin
                        addr_d  = addr0;
                        wdata_d = wdata0;
                        wen_d   = wstrb0;
                    end
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = SETTLE;
            end
            // Status from the cache is stale here: it has not seen the command yet.
            SETTLE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (complete) begin
                    if (!is_write) begin
                        rdata_d = cache_data_out;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    err_d   = 1'b0;
                    done_d  = grant_q;
                    wen_d   = 4'b0000;
                    state_d = DONE;
                end else if (cnt_q == CNT_MAX) begin
                    err_d   = 1'b1;
                    done_d  = grant_q;
                    wen_d   = 4'b0000;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                grant_d = 2'b00;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                grant_d = 2'b00;
                wen_d   = 4'b0000;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            grant_q <= 2'b00;
            done_q  <= 2'b00;
            err_q   <= 1'b0;
            rdata_q <= 32'h0000_0000;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            wen_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
        end
    end

    assign done               = done_q;
    assign err                = err_q;
    assign rdata              = rdata_q;
    assign grant              = grant_q;
    assign cache_address      = addr_q;
    assign cache_data_in      = wdata_q;
    assign cache_write_enable = wen_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: a behavioural cache answers commands,
// expected completions are queued at issue time and checked on done.
module tb_cache_arbiter;

    typedef struct {
        int          who;
        bit          is_read;
        bit          e_err;
        logic [3:0]  wstrb;
        logic [31:0] data;
        int          len;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] w;
        logic [3:0]  s;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [3:0]  wstrb0, wstrb1;
    logic [1:0]  done, grant;
    logic        err;
    logic [31:0] rdata, cache_address, cache_data_in, cache_data_out;
    logic [3:0]  cache_write_enable;
    logic        cache_data_out_ready, cache_busy;

    int total = 0;
    int bad   = 0;
    exp_t sb[$];
    txn_t pend0[$];
    txn_t pend1[$];
    int   busy_len = 0;
    bit   hang = 1'b0;

    always #5 clk = ~clk;

    cache_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .req(req),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .wstrb0(wstrb0), .wstrb1(wstrb1),
        .done(done), .err(err), .rdata(rdata), .grant(grant),
        .cache_address(cache_address), .cache_data_in(cache_data_in),
        .cache_write_enable(cache_write_enable),
        .cache_data_out(cache_data_out),
        .cache_data_out_ready(cache_data_out_ready), .cache_busy(cache_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Behavioural cache: a command is seen when grant rises.
    logic [31:0] mem [0:255];
    int          bcnt;
    bit          active;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_busy <= 1'b0;
            cache_data_out_ready <= 1'b0;
            cache_data_out <= 32'h0;
            bcnt <= 0;
            active <= 1'b0;
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
            mem[4] <= 32'h3433_3231;
        end else if (grant == 2'b00) begin
            cache_busy <= 1'b0;
            cache_data_out_ready <= 1'b0;
            active <= 1'b0;
        end else if (!active) begin
            active <= 1'b1;
            for (int b = 0; b < 4; b++)
                if (cache_write_enable[b]) mem[cache_address[9:2]][8*b +: 8] <= cache_data_in[8*b +: 8];
            if (hang || busy_len != 0) begin
                cache_busy <= 1'b1;
                cache_data_out_ready <= 1'b0;
                bcnt <= busy_len;
            end else begin
                cache_busy <= 1'b0;
                cache_data_out_ready <= (cache_write_enable == 4'b0000);
                cache_data_out <= mem[cache_address[9:2]];
            end
        end else if (!hang && bcnt != 0) begin
            bcnt <= bcnt - 1;
            if (bcnt == 1) begin
                cache_busy <= 1'b0;
                cache_data_out_ready <= (cache_write_enable == 4'b0000);
                cache_data_out <= mem[cache_address[9:2]];
            end
        end
    end

    task automatic load(input int i);
        txn_t t;
        if (i == 0) begin
            if (pend0.size() != 0) begin
                t = pend0.pop_front();
                addr0 = t.a; wdata0 = t.w; wstrb0 = t.s; req[0] = 1'b1;
            end else req[0] = 1'b0;
        end else begin
            if (pend1.size() != 0) begin
                t = pend1.pop_front();
                addr1 = t.a; wdata1 = t.w; wstrb1 = t.s; req[1] = 1'b1;
            end else req[1] = 1'b0;
        end
    endtask

    // Requester driver: holds req until done, then loads the next pending op.
    initial begin
        logic [1:0] d;
        req = 2'b00;
        addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0;
        wstrb0 = 4'h0; wstrb1 = 4'h0;
        forever begin
            @(posedge clk);
            d = done;
            #1;
            if (rst) req = 2'b00;
            else for (int i = 0; i < 2; i++) if (!req[i] || d[i]) load(i);
        end
    end

    // Monitor: grant/strobe while busy, scoreboard pop on each done.
    int          glen;
    logic [31:0] rd_model;
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] exp_rd;
        logic [1:0]  oh;
        if (rst) begin
            glen = 0;
            rd_model = 32'h0;
        end else begin
            if (grant != 2'b00 && done == 2'b00) begin
                if (sb.size() == 0) chk("grant_unexpected", {30'd0, grant}, 32'd0);
                else begin
                    oh = (sb[0].who == 1) ? 2'b10 : 2'b01;
                    chk("grant", {30'd0, grant}, {30'd0, oh});
                    chk("cwe_busy", {28'd0, cache_write_enable}, {28'd0, sb[0].wstrb});
                    glen++;
                end
            end else if (grant == 2'b00) begin
                chk("cwe_idle", {28'd0, cache_write_enable}, 32'd0);
            end
            if (done != 2'b00) begin
                if (sb.size() == 0) chk("done_unexpected", {30'd0, done}, 32'd0);
                else begin
                    e = sb.pop_front();
                    oh = (e.who == 1) ? 2'b10 : 2'b01;
                    chk("done", {30'd0, done}, {30'd0, oh});
                    chk("grant_at_done", {30'd0, grant}, {30'd0, oh});
                    chk("err", {31'd0, err}, {31'd0, e.e_err});
                    chk("cwe_done", {28'd0, cache_write_enable}, 32'd0);
                    exp_rd = (e.is_read && !e.e_err) ? e.data : rd_model;
                    chk("rdata", rdata, exp_rd);
                    rd_model = exp_rd;
                    if (e.len != 0) chk("latency", 32'(glen), 32'(e.len));
                end
                glen = 0;
            end
        end
    end

    task automatic issue(input int who, input logic [31:0] a, input logic [31:0] w,
                         input logic [3:0] s, input bit e_err, input logic [31:0] e_data,
                         input int e_len);
        exp_t e;
        txn_t t;
        e.who = who; e.is_read = (s == 4'b0000); e.e_err = e_err;
        e.wstrb = s; e.data = e_data; e.len = e_len;
        sb.push_back(e);
        t.a = a; t.w = w; t.s = s;
        if (who == 0) pend0.push_back(t);
        else pend1.push_back(t);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || req != 2'b00) && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain"}, {31'd0, (n < 600)}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_grant"}, {30'd0, grant}, 32'd0);
        chk({tag, "_done"}, {30'd0, done}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_addr"}, cache_address, 32'd0);
        chk({tag, "_wdata"}, cache_data_in, 32'd0);
        chk({tag, "_cwe"}, {28'd0, cache_write_enable}, 32'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("rst_hold");
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("rst_state");

        // Tie straight after reset: requester 0 first.
        issue(0, 32'h10, 32'h0, 4'h0, 1'b0, 32'h3433_3231, 3);
        issue(1, 32'h20, 32'h0, 4'h0, 1'b0, 32'hA5A5_0008, 3);
        wait_drain("tie");

        // Continuous requests alternate.
        busy_len = 2;
        for (int k = 0; k < 3; k++) begin
            issue(0, 32'h40 + 32'(4*k), 32'h0, 4'h0, 1'b0, 32'hA5A5_0010 + 32'(k), 0);
            issue(1, 32'h80 + 32'(4*k), 32'h0, 4'h0, 1'b0, 32'hA5A5_0020 + 32'(k), 0);
        end
        wait_drain("fair");

        busy_len = 10;
        issue(0, 32'h10, 32'h0, 4'h0, 1'b0, 32'h3433_3231, 0);
        wait_drain("single");

        busy_len = 3;
        issue(1, 32'h100, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, 0);
        issue(1, 32'h100, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF, 0);
        wait_drain("wr_rd");

        // Stuck cache: ISSUE + SETTLE + 16 WAIT cycles, then err.
        hang = 1'b1;
        issue(0, 32'h20, 32'h0, 4'h0, 1'b1, 32'h0, 18);
        wait_drain("timeout");
        hang = 1'b0;
        busy_len = 1;
        issue(1, 32'h20, 32'h0, 4'h0, 1'b0, 32'hA5A5_0008, 0);
        wait_drain("after_to");

        // Reset in the middle of WAIT.
        busy_len = 30;
        issue(0, 32'h10, 32'h0, 4'h0, 1'b0, 32'h3433_3231, 0);
        n = 0;
        while (grant == 2'b00 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_wait_grant", {31'd0, (n < 50)}, 32'd1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_mid");
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        busy_len = 0;
        issue(0, 32'h10, 32'h0, 4'h0, 1'b0, 32'h3433_3231, 3);
        issue(1, 32'h20, 32'h0, 4'h0, 1'b0, 32'hA5A5_0008, 3);
        wait_drain("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
